serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor. Loads two WIDTH-bit operands in parallel on a start handshake and processes one bit per clock, LSB first, through a single full-adder cell with a registered carry. It delivers the parallel sum, carry-out and signed overflow with a one-cycle done pulse. It is the datapath arithmetic unit for area-constrained blocks where one full adder plus shift registers is preferred over a WIDTH-bit ripple adder.

---
 rtl/serial_addsub_pkg.sv | 25 ++
 rtl/serial_fa_cell.sv | 40 ++++
 rtl/serial_addsub.sv | 148 ++++++++++++++
 tb/tb_serial_addsub.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  localparam int MIN_WIDTH = 32'd2;
  localparam int MAX_WIDTH = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; sizes the bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with registered carry. c_msb_in_o is the carry entering the
// bit being processed, so on the final bit it is the carry into the MSB.
module serial_fa_cell (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic load_i,
  input  logic cin_init_i,
  input  logic en_i,
  output logic s_o,
  output logic carry_o,
  output logic c_msb_in_o
);

  logic carry_q;
  logic carry_d;

  // Sum bit and carry-out of the bit currently presented.
  always_comb begin
    s_o        = a_i ^ b_i ^ carry_q;
    carry_d    = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);
    carry_o    = carry_d;
    c_msb_in_o = carry_q;
  end

  // Carry register: seeded on accept, advanced once per processed bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= cin_init_i;
    end else if (en_i) begin
      carry_q <= carry_d;
    end else begin
      carry_q <= carry_q;
    end
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one full adder plus shift registers.
// Optional serial result stream enabled by defining SERIAL_ADDSUB_STREAM_EN.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_in_i,
  input  logic [WIDTH-1:0] b_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
`ifdef SERIAL_ADDSUB_STREAM_EN
  ,
  output logic             s_out_o,
  output logic             s_valid_o
`endif
);

  localparam int CW = clog2(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_addsub: WIDTH outside supported range");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic             accept;
  logic             run_en;
  logic             last_bit;
  logic             fa_s;
  logic             fa_carry;
  logic             fa_c_msb_in;

  serial_fa_cell u_fa (
    .clk        (clk),
    .rst        (rst),
    .a_i        (a_q[0]),
    .b_i        (b_q[0]),
    .load_i     (accept),
    .cin_init_i (sub_i),
    .en_i       (run_en),
    .s_o        (fa_s),
    .carry_o    (fa_carry),
    .c_msb_in_o (fa_c_msb_in)
  );

  // Handshake decode and the shifted register images for the next RUN edge.
  always_comb begin
    accept   = 1'b0;
    run_en   = 1'b0;
    case (state_q)
      ST_IDLE: accept = start_i;
      ST_DONE: accept = start_i;
      ST_RUN:  run_en = 1'b1;
      default: begin
        accept = 1'b0;
        run_en = 1'b0;
      end
    endcase
    last_bit = (cnt_q == CW'(WIDTH - 1));
    a_d      = {fa_s, a_q[WIDTH-1:1]};
    b_d      = {1'b0, b_q[WIDTH-1:1]};
  end

  // Control FSM with shift registers, bit counter and registered results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            a_q     <= a_in_i;
            b_q     <= sub_i ? ~b_in_i : b_in_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + CW'(1'b1);
          if (last_bit) begin
            // a_d already holds every sum bit once the MSB is shifted in.
            sum_q   <= a_d;
            cout_q  <= fa_carry;
            ovf_q   <= fa_c_msb_in ^ fa_carry;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

`ifdef SERIAL_ADDSUB_STREAM_EN
  // Gated by busy so the stream idles at 0 outside RUN.
  assign s_out_o   = busy_q & fa_s;
  assign s_valid_o = busy_q;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH=8.
// Latency counts edges with the start edge E0 as edge 1, so done appears at count 9.
module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       sub_i;
  logic [7:0] a_in_i;
  logic [7:0] b_in_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sum_o;
  logic       cout_o;
  logic       ovf_o;
`ifdef SERIAL_ADDSUB_STREAM_EN
  logic       s_out_o;
  logic       s_valid_o;
`endif

  int checks;
  int errors;

  serial_addsub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .sub_i     (sub_i),
    .a_in_i    (a_in_i),
    .b_in_i    (b_in_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sum_o     (sum_o),
    .cout_o    (cout_o),
    .ovf_o     (ovf_o)
`ifdef SERIAL_ADDSUB_STREAM_EN
    ,
    .s_out_o   (s_out_o),
    .s_valid_o (s_valid_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one operation and wait (bounded) for done; lat = 0 on timeout.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    @(negedge clk);
    a_in_i = a; b_in_i = b; sub_i = s; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_o) lat = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy_o, done_o, sum_o, cout_o, ovf_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy_o, done_o, sum_o, cout_o, ovf_o);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_add_basic();
    int lat, busy_cnt;
    @(negedge clk);
    a_in_i = 8'h0A; b_in_i = 8'h03; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    busy_cnt = busy_o ? 1 : 0;
    while (!done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_o) busy_cnt++;
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL add_latency: got %0d want 9", lat); end
    checks++;
    if (busy_cnt !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d want 8", busy_cnt); end
    checks++;
    if ({sum_o, cout_o, ovf_o} !== {8'h0D, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_0a_03: got sum=%h cout=%b ovf=%b want 0d 0 0", sum_o, cout_o, ovf_o);
    end
    @(posedge clk); #1;
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done still %b want 0", done_o); end
  endtask

  task automatic test_add_boundaries();
    int lat;
    do_op(8'h7F, 8'h01, 1'b0, lat);
    checks++;
    if ({sum_o, cout_o, ovf_o, lat} !== {8'h80, 1'b1 ^ 1'b1, 1'b1, 32'd9}) begin
      errors++;
      $display("FAIL add_7f_01: got sum=%h cout=%b ovf=%b lat=%0d want 80 0 1 9", sum_o, cout_o, ovf_o, lat);
    end
    do_op(8'hFF, 8'h01, 1'b0, lat);
    checks++;
    if ({sum_o, cout_o, ovf_o, lat} !== {8'h00, 1'b1, 1'b0, 32'd9}) begin
      errors++;
      $display("FAIL add_ff_01: got sum=%h cout=%b ovf=%b lat=%0d want 00 1 0 9", sum_o, cout_o, ovf_o, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a_in_i = 8'h01; b_in_i = 8'h02; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    a_in_i = 8'h10; b_in_i = 8'h20;
    lat = 1;
    while (!done_o && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({sum_o, lat} !== {8'h03, 32'd9}) begin
      errors++;
      $display("FAIL b2b_first: got sum=%h lat=%0d want 03 9", sum_o, lat);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if ({done_o, busy_o} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept: got done=%b busy=%b want 0 1", done_o, busy_o);
    end
    lat = 1;
    while (!done_o && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({sum_o, lat} !== {8'h30, 32'd9}) begin
      errors++;
      $display("FAIL b2b_second: got sum=%h spacing=%0d want 30 9", sum_o, lat);
    end
  endtask

  task automatic test_mid_run_ignore();
    int lat;
    @(negedge clk);
    a_in_i = 8'h0A; b_in_i = 8'h03; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    a_in_i = 8'hFF; b_in_i = 8'hFF; sub_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    lat++;
    start_i = 1'b0;
    while (!done_o && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({sum_o, cout_o, ovf_o, lat} !== {8'h0D, 1'b0, 1'b0, 32'd9}) begin
      errors++;
      $display("FAIL mid_run_start: got sum=%h cout=%b ovf=%b lat=%0d want 0d 0 0 9", sum_o, cout_o, ovf_o, lat);
    end
  endtask

  task automatic test_subtract();
    int lat;
    do_op(8'h05, 8'h07, 1'b1, lat);
    checks++;
    if ({sum_o, cout_o, ovf_o, lat} !== {8'hFE, 1'b0, 1'b0, 32'd9}) begin
      errors++;
      $display("FAIL sub_05_07: got sum=%h cout=%b ovf=%b lat=%0d want fe 0 0 9", sum_o, cout_o, ovf_o, lat);
    end
    do_op(8'h80, 8'h01, 1'b1, lat);
    checks++;
    if ({sum_o, cout_o, ovf_o, lat} !== {8'h7F, 1'b1, 1'b1, 32'd9}) begin
      errors++;
      $display("FAIL sub_80_01: got sum=%h cout=%b ovf=%b lat=%0d want 7f 1 1 9", sum_o, cout_o, ovf_o, lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit seen;
    @(negedge clk);
    a_in_i = 8'h0A; b_in_i = 8'h03; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, sum_o, cout_o, ovf_o} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy_o, done_o, sum_o, cout_o, ovf_o);
    end
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_o || busy_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_done: activity seen=%b want 0", seen); end
    do_op(8'h0A, 8'h03, 1'b0, lat);
    checks++;
    if ({sum_o, lat} !== {8'h0D, 32'd9}) begin
      errors++;
      $display("FAIL after_reset_add: got sum=%h lat=%0d want 0d 9", sum_o, lat);
    end
  endtask

`ifdef SERIAL_ADDSUB_STREAM_EN
  task automatic test_stream();
    logic [7:0] exp_bits;
    logic [7:0] got_bits;
    int lat;
    exp_bits = 8'h0D;
    got_bits = 8'h00;
    @(negedge clk);
    a_in_i = 8'h0A; b_in_i = 8'h03; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (s_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid bit %0d: got %b want 1", i, s_valid_o); end
      got_bits[i] = s_out_o;
    end
    checks++;
    if (got_bits !== exp_bits) begin
      errors++;
      $display("FAIL stream_bits: got %b want %b (LSB first)", got_bits, exp_bits);
    end
    lat = 0;
    while (!done_o && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (s_valid_o !== 1'b0) begin errors++; $display("FAIL stream_valid_end: got %b want 0", s_valid_o); end
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    start_i = 1'b0;
    sub_i   = 1'b0;
    a_in_i  = 8'h00;
    b_in_i  = 8'h00;
    test_reset();
    test_add_basic();
    test_add_boundaries();
    test_back_to_back();
    test_mid_run_ignore();
    test_subtract();
    test_reset_mid_run();
`ifdef SERIAL_ADDSUB_STREAM_EN
    test_stream();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
